// File: rtl/debug_uart_tx_pkg.sv
// Shared types and constants for the debug-bus UART logger.
// Purely declarative: no logic, no latency.
// Backpressure: not applicable.
//
// Contents: debug bus width, CR/LF codes, serializer state enum and the
// nibble-to-uppercase-hex helper used to build frame characters.
package debug_uart_tx_pkg;

    localparam int DEBUG_WIDTH = 16;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Characters per frame: four hex digits, CR, LF.
    localparam logic [2:0] FRAME_CHARS = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 UART serializer with a byte valid/ready handshake.
// Latency: an accepted byte puts its start bit on tx the next cycle.
// Backpressure: byte_rdy only when idle or in the last cycle of a stop bit.
//
// Ports: clk, rst (async, active-low); byte_dat/byte_vld/byte_rdy byte
// handshake; tx registered serial output, idle high.
module uart_byte_tx
    import debug_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_dat,
    input  logic       byte_vld,
    output logic       byte_rdy,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_tx_state_t   state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // Accepting in the stop bit's final cycle lets the next start bit follow
    // with no idle gap between characters.
    assign byte_rdy = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign tx       = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A new byte overrides whatever the state decode chose above.
        if (byte_vld && byte_rdy) begin
            state_d = START;
            baud_d  = '0;
            bit_d   = 3'd0;
            shift_d = byte_dat;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Logs the core debug bus over UART as "HHHH\r\n" on change or on request.
// Latency: start bit on tx one cycle after the start condition is seen.
// Backpressure: none upstream; changes while busy collapse to the latest value.
//
// Ports: clk, rst (async, active-low); debug_in value to log; enable gates
// new frames; send_req forces a frame; tx UART pin; busy frame in progress;
// overrun_count saturating count of debug_in changes seen while busy.
module debug_uart_tx
    import debug_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 868,
    parameter int DEBUG_WIDTH   = debug_uart_tx_pkg::DEBUG_WIDTH,
    parameter int OVERRUN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DEBUG_WIDTH-1:0]   debug_in,
    input  logic                     enable,
    input  logic                     send_req,
    output logic                     tx,
    output logic                     busy,
    output logic [OVERRUN_WIDTH-1:0] overrun_count
);

    // The top nibble goes straight from debug_in to the serializer in the
    // start cycle, so only the remaining 12 bits need holding.
    logic [DEBUG_WIDTH-5:0]   frame_lo_q, frame_lo_d;
    logic [DEBUG_WIDTH-1:0]   last_sent_q, last_sent_d;
    logic [DEBUG_WIDTH-1:0]   debug_prev_q;
    logic [OVERRUN_WIDTH-1:0] overrun_q, overrun_d;
    logic [2:0]               char_idx_q, char_idx_d;
    logic                     active_q, active_d;
    logic                     pending_q, pending_d;

    logic                     start;
    logic                     byte_vld;
    logic                     byte_rdy;
    logic [7:0]               byte_dat;

    assign start = !active_q && enable &&
                   ((debug_in != last_sent_q) || send_req || pending_q);

    // Character feed: char 0 in the start cycle, chars 1..5 from the latch.
    always_comb begin
        byte_vld = 1'b0;
        byte_dat = 8'h00;
        if (start) begin
            byte_vld = 1'b1;
            byte_dat = nibble_to_ascii(debug_in[DEBUG_WIDTH-1 -: 4]);
        end else if (active_q && (char_idx_q < FRAME_CHARS)) begin
            byte_vld = 1'b1;
            case (char_idx_q)
                3'd1:    byte_dat = nibble_to_ascii(frame_lo_q[11:8]);
                3'd2:    byte_dat = nibble_to_ascii(frame_lo_q[7:4]);
                3'd3:    byte_dat = nibble_to_ascii(frame_lo_q[3:0]);
                3'd4:    byte_dat = ASCII_CR;
                3'd5:    byte_dat = ASCII_LF;
                default: byte_dat = 8'h00;
            endcase
        end
    end

    always_comb begin
        active_d    = active_q;
        char_idx_d  = char_idx_q;
        frame_lo_d  = frame_lo_q;
        last_sent_d = last_sent_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;

        if (start) begin
            active_d    = 1'b1;
            char_idx_d  = 3'd1;
            frame_lo_d  = debug_in[DEBUG_WIDTH-5:0];
            last_sent_d = debug_in;
            pending_d   = 1'b0;
        end else if (active_q) begin
            if (send_req) begin
                pending_d = 1'b1;
            end
            if (byte_rdy) begin
                if (char_idx_q < FRAME_CHARS) begin
                    char_idx_d = char_idx_q + 1'b1;
                end else begin
                    // Ready with nothing left to send means the LF stop bit
                    // is in its final cycle: the frame ends here.
                    active_d = 1'b0;
                end
            end
        end

        if (active_q && (debug_in != debug_prev_q) &&
            (overrun_q != {OVERRUN_WIDTH{1'b1}})) begin
            overrun_d = overrun_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q     <= 1'b0;
            char_idx_q   <= 3'd0;
            frame_lo_q   <= '0;
            last_sent_q  <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= '0;
            debug_prev_q <= '0;
        end else begin
            active_q     <= active_d;
            char_idx_q   <= char_idx_d;
            frame_lo_q   <= frame_lo_d;
            last_sent_q  <= last_sent_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            debug_prev_q <= debug_in;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk      (clk),
        .rst      (rst),
        .byte_dat (byte_dat),
        .byte_vld (byte_vld),
        .byte_rdy (byte_rdy),
        .tx       (tx)
    );

    assign busy          = active_q;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
module tb_debug_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] debug_in = 16'h0000;
    logic        enable = 1'b0;
    logic        send_req = 1'b0;
    logic        tx;
    logic        busy;
    logic [7:0]  overrun_count;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    debug_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEBUG_WIDTH  (16),
        .OVERRUN_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .debug_in     (debug_in),
        .enable       (enable),
        .send_req     (send_req),
        .tx           (tx),
        .busy         (busy),
        .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    // UART receiver: samples each bit mid-way, cycle counted at negedges.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'h00;
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    int         rx_bit = 0;
    int         rx_ferr = 0;

    always @(negedge clk) begin
        if (!rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                rx_bit = rx_cnt / CPB;
                if (rx_bit >= 1 && rx_bit <= 8) begin
                    rx_sh[rx_bit-1] = tx;
                end else if (rx_bit == 9) begin
                    if (tx !== 1'b1) rx_ferr++;
                    rx_q.push_back(rx_sh);
                    rx_act = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called with busy already high; counts busy cycles including the current one.
    task automatic run_until_idle(output int len);
        len = 0;
        while (busy === 1'b1 && len < 2000) begin
            len++;
            tick();
        end
    endtask

    // Counts cycles in which the line is not idle over a window.
    task automatic quiet(input int n, output int act);
        act = 0;
        for (int i = 0; i < n; i++) begin
            if (busy !== 1'b0 || tx !== 1'b1) act++;
            tick();
        end
    endtask

    task automatic expect_frame(input string tag, input string hex4);
        logic [7:0] e[6];
        int w;
        w = 0;
        while (rx_q.size() < 6 && w < 3000) begin
            w++;
            tick();
        end
        check({tag, "_nchars"}, 32'(rx_q.size() >= 6), 32'd1);
        if (rx_q.size() < 6) return;
        for (int i = 0; i < 4; i++) e[i] = hex4[i];
        e[4] = 8'h0D;
        e[5] = 8'h0A;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_ch%0d", tag, i), 32'(rx_q.pop_front()), 32'(e[i]));
        end
    endtask

    initial begin
        int len;
        int act;
        int gap;

        // Reset state
        repeat (3) tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun_count), 32'd0);
        rst = 1'b1;
        enable = 1'b1;

        // Unchanged zero value: no frame; then a send_req forces one
        quiet(1000, act);
        check("idle_quiet", 32'(act), 32'd0);
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
        check("req_start_tx", 32'(tx), 32'd0);
        check("req_start_busy", 32'(busy), 32'd1);
        expect_frame("req0000", "0000");
        run_until_idle(len);

        // Value change: start bit next cycle, 240 busy cycles, "1A2F\r\n"
        debug_in = 16'h1A2F;
        tick();
        check("chg_start_tx", 32'(tx), 32'd0);
        check("chg_start_busy", 32'(busy), 32'd1);
        run_until_idle(len);
        check("chg_busy_len", 32'(len), 32'd240);
        check("chg_idle_tx", 32'(tx), 32'd1);
        expect_frame("f1A2F", "1A2F");

        // send_req coincident with a change yields a single frame
        debug_in = 16'hF00D;
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
        run_until_idle(len);
        check("coin_busy_len", 32'(len), 32'd240);
        expect_frame("fF00D", "F00D");
        quiet(300, act);
        check("coin_single", 32'(act), 32'd0);
        check("coin_noextra", 32'(rx_q.size()), 32'd0);

        // Three requests inside one frame give exactly one extra frame
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
        len = 0;
        for (int c = 0; c < 2000 && busy === 1'b1; c++) begin
            send_req = (c == 50 || c == 100 || c == 150);
            len++;
            tick();
        end
        send_req = 1'b0;
        check("pend_len1", 32'(len), 32'd240);
        gap = 0;
        while (busy === 1'b0 && gap < 10) begin
            gap++;
            tick();
        end
        check("pend_gap", 32'(gap), 32'd1);
        run_until_idle(len);
        check("pend_len2", 32'(len), 32'd240);
        quiet(300, act);
        check("pend_no_third", 32'(act), 32'd0);
        expect_frame("pend_a", "F00D");
        expect_frame("pend_b", "F00D");

        // Reset asserted during the start bit of char 2 aborts the frame
        debug_in = 16'hBEEF;
        tick();
        check("rstmid_busy0", 32'(busy), 32'd1);
        repeat (81) tick();
        check("rstmid_pre_tx", 32'(tx), 32'd0);
        rst = 1'b0;
        #1;
        check("rstmid_tx", 32'(tx), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        rx_q.delete();
        rst = 1'b1;
        tick();
        check("rstmid_restart", 32'(busy), 32'd1);
        expect_frame("fBEEF", "BEEF");
        run_until_idle(len);
        check("rstmid_overrun", 32'(overrun_count), 32'd0);

        // Three changes mid-frame: overrun 3, only the latest value follows
        debug_in = 16'h0001;
        tick();
        repeat (20) tick();
        debug_in = 16'h0002;
        tick();
        debug_in = 16'h0004;
        tick();
        debug_in = 16'h0003;
        tick();
        tick();
        check("ovr_count3", 32'(overrun_count), 32'd3);
        expect_frame("f0001", "0001");
        expect_frame("f0003", "0003");
        run_until_idle(len);
        quiet(300, act);
        check("ovr_no_more", 32'(act), 32'd0);
        check("ovr_no_0002", 32'(rx_q.size()), 32'd0);

        // 300 changes while busy: counter saturates at 255
        debug_in = 16'h1234;
        tick();
        for (int i = 0; i < 300; i++) begin
            debug_in = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
            tick();
        end
        check("ovr_sat", 32'(overrun_count), 32'd255);
        act = 0;
        len = 0;
        while (act < 300 && len < 5000) begin
            if (busy === 1'b1) act = 0;
            else act++;
            len++;
            tick();
        end
        rx_q.delete();
        check("ovr_sat_hold", 32'(overrun_count), 32'd255);

        // enable dropped mid-frame: frame completes, later change held off
        debug_in = 16'h7777;
        tick();
        repeat (50) tick();
        enable = 1'b0;
        run_until_idle(len);
        check("en_finish_len", 32'(len), 32'd190);
        expect_frame("f7777", "7777");
        debug_in = 16'h9D04;
        quiet(300, act);
        check("en_held", 32'(act), 32'd0);
        enable = 1'b1;
        tick();
        check("en_resume_busy", 32'(busy), 32'd1);
        check("en_resume_tx", 32'(tx), 32'd0);
        expect_frame("f9D04", "9D04");
        run_until_idle(len);
        enable = 1'b0;
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        quiet(300, act);
        check("en_req_dropped", 32'(act), 32'd0);

        check("rx_framing", 32'(rx_ferr), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
